// File: rtl/arb_rr.sv
// ---------------------------------------------------------------------------
// arb_rr -- round-robin arbiter with a registered one-hot grant and a
// valid/ready output handshake.
//
// Exactly one grant bit is set whenever gnt_valid is high, and gnt is all-zero
// otherwise. The downstream index encoder relies on this and can therefore run
// without priority resolution. A grant is held stable while gnt_ready is low.
// The priority pointer only moves when a grant is accepted.
//
// Parameters
//   W          number of requesters (>= 2, any value)
//   E          width of the internal priority pointer, $clog2(W) by default
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   req        [W-1:0] request vector, bit i = requester i wants a grant
//   gnt_ready  downstream accepts the presented grant this cycle
//   gnt_valid  grant register holds a valid grant
//   gnt        [W-1:0] one-hot grant, zero when gnt_valid is low
//   lock       (ARB_RR_LOCK_EN only) repeat the current grant after acceptance
//              while its requester is still asking
//
// Optional feature macro: ARB_RR_LOCK_EN. When it is undefined there is no
// lock port and the arbiter is pure round-robin.
// ---------------------------------------------------------------------------
module arb_rr #(
  parameter int W = 32,
  parameter int E = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] req,
  input  logic         gnt_ready,
`ifdef ARB_RR_LOCK_EN
  input  logic         lock,
`endif
  output logic         gnt_valid,
  output logic [W-1:0] gnt
);

  // Two-state machine encoded directly by the grant-valid flop.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [E-1:0] p_q, p_d;
  logic         gnt_valid_q, gnt_valid_d;
  logic [W-1:0] gnt_q, gnt_d;

  logic [E-1:0] gnt_idx;
  logic [E-1:0] next_idx;
  logic [E-1:0] arb_base;
  logic [W-1:0] win_oh;
  logic         win_any;
  logic         accept;
  logic         hold_burst;

  // Round-robin pick starting at 'base' and wrapping modulo W. The first
  // pass only looks at requesters at or above the base; if that finds
  // nothing, the second pass takes the lowest requester overall. Together
  // these give the wrapped scan base, base+1, ..., W-1, 0, ..., base-1
  // without needing a modulo on non-power-of-two W.
  function automatic logic [W-1:0] rr_pick(input logic [W-1:0] r,
                                           input logic [E-1:0] base);
    logic [W-1:0] pick;
    logic         found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!found && r[i] && (E'(i) >= base)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < W; i++) begin
      if (!found && r[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    return pick;
  endfunction

  // Encode the currently held one-hot grant back to an index, and compute
  // the index after it, wrapping W-1 back to 0. The grant is one-hot by
  // construction, so a plain OR-style scan is enough.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (gnt_q[i]) begin
        gnt_idx = E'(i);
      end
    end
    if (gnt_idx == E'(W - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = gnt_idx + E'(1);
    end
  end

  // A single arbiter serves both the idle case and the same-cycle
  // re-arbitration on accept. On accept it must already use the advanced
  // pointer, so the base is muxed here rather than waiting for p_q.
  always_comb begin
    accept   = (gnt_valid_q == ST_GRANT) && gnt_ready;
    arb_base = (gnt_valid_q == ST_GRANT) ? next_idx : p_q;
    win_oh   = rr_pick(req, arb_base);
    win_any  = |win_oh;
  end

  // A locked burst repeats the same grant only if that requester is still
  // asking; otherwise the accept falls through to normal arbitration.
  always_comb begin
`ifdef ARB_RR_LOCK_EN
    hold_burst = accept && lock && |(req & gnt_q);
`else
    hold_burst = 1'b0;
`endif
  end

  // Next-state logic. In GRANT without ready everything holds, so request
  // changes (even the granted bit dropping) are ignored until the accept.
  // In IDLE gnt_ready has no effect.
  always_comb begin
    p_d         = p_q;
    gnt_valid_d = gnt_valid_q;
    gnt_d       = gnt_q;
    if (gnt_valid_q == ST_IDLE) begin
      gnt_valid_d = win_any ? ST_GRANT : ST_IDLE;
      gnt_d       = win_oh;
    end else if (accept) begin
      if (hold_burst) begin
        gnt_d = gnt_q;
      end else begin
        p_d         = next_idx;
        gnt_valid_d = win_any ? ST_GRANT : ST_IDLE;
        gnt_d       = win_oh;
      end
    end
  end

  // State registers. Reset discards any pending grant and restarts the
  // pointer at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      gnt_valid_q <= ST_IDLE;
      gnt_q       <= '0;
    end else begin
      p_q         <= p_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_q       <= gnt_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt       = gnt_q;

endmodule

// File: tb/tb_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_arb_rr -- directed scoreboard bench for arb_rr with W = 4.
//
// Each stimulus step drives inputs, waits one rising edge and records what the
// arbiter should present in the following cycle. Expected grants go into a
// queue; a monitor on the falling edge pops one entry for every cycle in which
// the arbiter presents gnt_valid and compares the grant. Idle cycles are
// checked directly. The lock scenario runs only when ARB_RR_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_arb_rr;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] req;
  logic         gnt_ready;
  logic         lockIn;
  logic         gnt_valid;
  logic [W-1:0] gnt;

  int vectors;
  int miscompares;

  logic [W-1:0] expQ[$];

  arb_rr #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
`ifdef ARB_RR_LOCK_EN
    .lock      (lockIn),
`endif
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge happen, then record the
  // expected output for the cycle that follows that edge.
  task automatic applyStimulus(input string name, input logic rs,
                               input logic [W-1:0] r, input logic rdy,
                               input logic lk, input logic expValid,
                               input logic [W-1:0] expGnt);
    rst       = rs;
    req       = r;
    gnt_ready = rdy;
    lockIn    = lk;
    @(posedge clk);
    #1;
    checkOutput({name, ".valid"}, {31'd0, gnt_valid}, {31'd0, expValid});
    if (expValid) begin
      expQ.push_back(expGnt);
    end else begin
      checkOutput({name, ".idle_gnt"}, {28'd0, gnt}, 32'd0);
    end
  endtask

  // Monitor: every cycle the arbiter presents a grant, compare it with the
  // oldest expected grant and check the one-hot invariant.
  always @(negedge clk) begin
    if (gnt_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_grant: got %0h, expected no grant at %0t", gnt, $time);
      end else begin
        checkOutput("scoreboard_gnt", {28'd0, gnt}, {28'd0, expQ.pop_front()});
      end
      checkOutput("onehot", {31'd0, $onehot(gnt)}, 32'd1);
    end
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    req       = '0;
    gnt_ready = 1'b0;
    lockIn    = 1'b0;

    // Reset held for two edges with all requesters asking.
    applyStimulus("reset0", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus("reset1", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);

    // First edge out of reset grants requester 0.
    applyStimulus("first",  1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 4'b0001);

    // Fairness: back-to-back accepts rotate through all requesters.
    applyStimulus("fair1",  1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0010);
    applyStimulus("fair2",  1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0100);
    applyStimulus("fair3",  1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 4'b1000);
    applyStimulus("fair4",  1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 4'b0001);

    // Accept 0001 with req 0110: pointer 1, grant 0010.
    applyStimulus("bp_load", 1'b0, 4'b0110, 1'b1, 1'b0, 1'b1, 4'b0010);
    // Backpressure: grant holds although req changes and bit 1 drops.
    applyStimulus("bp1",    1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0010);
    applyStimulus("bp2",    1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0010);
    applyStimulus("bp3",    1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0010);
    applyStimulus("bp_acc", 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100);

    // Wrap: accept 0100 -> pointer 3, req 0011 wraps to requester 0, then 1.
    applyStimulus("wrap1",  1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001);
    applyStimulus("wrap2",  1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0010);
    // Accept with no requests left goes idle; ready in idle does nothing.
    applyStimulus("drain",  1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
    applyStimulus("idle",   1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

    // Pointer is 2: req 1001 picks requester 3, then hold under backpressure.
    applyStimulus("mid_load", 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b1000);
    applyStimulus("mid_hold", 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b1000);
    // Reset mid-grant drops it and restarts the pointer at 0.
    applyStimulus("mid_rst",  1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus("post_rst", 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 4'b0001);
    applyStimulus("post_acc", 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1, 4'b1000);
    applyStimulus("post_end", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);

`ifdef ARB_RR_LOCK_EN
    // Lock: pointer 0, req 1010 grants 0010 and the locked burst repeats it.
    applyStimulus("lk_load", 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0010);
    applyStimulus("lk1",     1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 4'b0010);
    applyStimulus("lk2",     1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 4'b0010);
    applyStimulus("lk_rel",  1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 4'b1000);
    // Lock with the granted requester gone: normal arbitration, pointer wraps.
    applyStimulus("lk_gone", 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010);
    applyStimulus("lk_end",  1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000);
`endif

    // Let the monitor consume the last entries, then every expected grant
    // must have been seen.
    applyStimulus("tail", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_rr.md
# arb_rr

Round-robin arbiter with a registered one-hot grant and a valid/ready output handshake. It sits directly upstream of the index encoder. It guarantees exactly one grant bit is set whenever `gnt_valid` is high, so the downstream encoder can run in its fast, non-priority mode (`OPT_PRIORITY = 0`). The block arbitrates among `W` requesters, holds the grant stable under backpressure, and advances its priority pointer only on an accepted grant.

## Interface
- `W`, default 32: number of requesters; any value ≥ 2, power of two not required.
- `E`, default `$clog2(W)`: width of the internal priority pointer.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  W: request vector; bit i high means requester i wants a grant.
- `gnt_ready`  in  1: downstream accepts the grant this cycle.
- `gnt_valid`  out  1: the grant register holds a valid grant.
- `gnt`  out  W: one-hot grant vector; all-zero when `gnt_valid` = 0.
- `lock`  in  1: present only with `ARB_RR_LOCK_EN`; requests that the current grant repeat after acceptance.

## Operation
- Internal state:
  - Priority pointer `p` (E bits, range 0..W-1).
  - Output registers `gnt_valid` and `gnt`.
- Two states, encoded by `gnt_valid`:
  - IDLE (`gnt_valid` = 0).
  - GRANT (`gnt_valid` = 1).
- Arbitration function: scan `req` in the order p, p+1, …, W-1, 0, …, p-1, wrapping modulo W. The first set bit wins.
- IDLE:
  - If `req` ≠ 0, load `gnt` with the winner's one-hot and go to GRANT.
  - If `req` = 0, stay in IDLE with `gnt` = 0.
- GRANT with `gnt_ready` = 0:
  - Hold `gnt` and `gnt_valid` unchanged.
  - Changes on `req` are ignored, including the granted bit dropping.
  - `p` is unchanged.
- GRANT with `gnt_ready` = 1 (accept), granted index i:
  - `p` ← (i+1) mod W. When i = W-1, `p` wraps to 0.
  - Re-arbitrate in the same cycle using current `req` and the updated `p`.
  - If a winner exists, load its one-hot and stay in GRANT. This gives back-to-back grants at full throughput.
  - Otherwise go to IDLE with `gnt` = 0.
- `gnt_ready` while in IDLE is ignored.
- Invariant: `gnt_valid` = 1 implies `$onehot(gnt)`; `gnt_valid` = 0 implies `gnt` = 0.
- Reset: `gnt_valid` = 0, `gnt` = 0, `p` = 0. Reset asserted mid-grant discards the pending grant; no accept is recorded.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled at edge t appears as `gnt_valid`/`gnt` after edge t.
- Accept-to-next-grant: 0 idle cycles. The new grant is visible the cycle after the accepting edge.
- No combinational path from any input to any output; all outputs are registered.
- First grant after reset: `req` sampled on the first edge with `rst` = 0; the grant is visible after that edge.

## Configuration
- `ARB_RR_LOCK_EN` defined:
  - The `lock` port exists.
  - On accept with `lock` = 1 and `req[i]` still high, `p` is not advanced and `gnt` is reloaded with index i. This holds a burst.
  - On accept with `lock` = 1 and `req[i]` low, normal arbitration runs with `p` ← (i+1) mod W.
  - `lock` is ignored when there is no accept.
- `ARB_RR_LOCK_EN` undefined: no `lock` port; pure round-robin as above.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `req` = 4'hF (W = 4).
  - During reset: `gnt_valid` = 0, `gnt` = 0.
  - After the first edge with `rst` = 0: `gnt` = 4'b0001.
- Fairness: `req` = 4'b1111, `gnt_ready` = 1 constantly.
  - Grants on consecutive cycles: 0001, 0010, 0100, 1000, 0001.
  - No bubble cycles.
- Backpressure: `req` = 4'b0110, `gnt_ready` = 0 for 3 cycles, with `req` changing to 4'b0100 in cycle 2.
  - `gnt` stays 4'b0010 for all 3 cycles.
  - Raising `gnt_ready` then yields a next grant of 4'b0100.
- Wrap: after an accepted grant of 4'b0100 (`p` = 3), set `req` = 4'b0011.
  - Next grant = 4'b0001.
  - After that is accepted, the next grant = 4'b0010.
- Lock (`ARB_RR_LOCK_EN` defined): `req` = 4'b1010, `gnt_ready` = 1, `lock` = 1 from the first grant of 4'b0010.
  - Grants: 0010, 0010, 0010.
  - With `lock` = 0 at the next accept: 1000.
- Reset mid-operation: `gnt_valid` = 1 with `gnt` = 4'b1000 and `gnt_ready` = 0, then pulse `rst` for 1 cycle with `req` = 4'b1001.
  - After the reset edge: `gnt_valid` = 0.
  - The next grant is 4'b0001, showing `p` was reset to 0.
